// File: rtl/fjpolo_simple_counter_pkg.sv
// Shared constants for the simple up/down counter.
// Holds ui_in bit positions, default widths and the prescaler mask helper.
package fjpolo_simple_counter_pkg;

    // ui_in control bit positions
    localparam int CNT_EN   = 0;
    localparam int DIR      = 1;
    localparam int LOAD     = 2;
    localparam int SAT      = 3;
    localparam int CLR      = 4;
    localparam int PSEL_LSB = 5;
    localparam int PSEL_MSB = 7;

    // Default count width and prescaler width
    localparam int DEF_WIDTH = 8;
    localparam int PRESC_W   = 7;

    // Terminal prescaler value for selector N: 2^N - 1
    function automatic logic [PRESC_W-1:0] presc_mask(input logic [2:0] sel);
        logic [7:0] w_full;
        w_full = (8'd1 << sel) - 8'd1;
        return w_full[PRESC_W-1:0];
    endfunction

endpackage

// File: rtl/fjpolo_simple_counter_prescaler.sv
// Programmable prescaler: 7-bit pcnt producing a tick every 2^sel run cycles.
// Ports: clk, rst_n (sync, active-low), run, clear, sel[2:0] -> tick.
module fjpolo_simple_counter_prescaler
    import fjpolo_simple_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clear,
    input  logic [2:0] sel,
    output logic       tick
);

    localparam logic [PRESC_W-1:0] PCNT_MAX = '1;

    logic [PRESC_W-1:0] r_pcnt;
    logic [PRESC_W-1:0] w_mask;
    logic               w_term;

    assign w_mask = presc_mask(sel);

    // A selector change can leave pcnt above the new terminal value;
    // the natural 7-bit rollover then provides the tick.
    assign w_term = (r_pcnt == w_mask) || (r_pcnt == PCNT_MAX);
    assign tick   = run & w_term;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pcnt <= '0;
        end else if (clear) begin
            r_pcnt <= '0;
        end else if (run) begin
            if (w_term) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fjpolo_simple_counter.sv
// Up/down counter with load, clear, wrap/saturate and prescaled stepping.
// Ports: clk, rst_n, ena, ui_in (control), uio_in (load value) -> uo_out (count);
// uio_out and uio_oe are tied to zero (all bidirectional pins are inputs).
module fjpolo_simple_counter
    import fjpolo_simple_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_next;
    logic [7:0]       w_out;

    logic       w_cnt_en;
    logic       w_dir;
    logic       w_load;
    logic       w_sat;
    logic       w_clr;
    logic [2:0] w_psel;
    logic       w_run;
    logic       w_pclear;
    logic       w_tick;
    logic       w_at_max;
    logic       w_at_min;

    assign w_cnt_en = ui_in[CNT_EN];
    assign w_dir    = ui_in[DIR];
    assign w_load   = ui_in[LOAD];
    assign w_sat    = ui_in[SAT];
    assign w_clr    = ui_in[CLR];
    assign w_psel   = ui_in[PSEL_MSB:PSEL_LSB];

    // Prescaler only advances on a plain count cycle; clr/load restart it.
    assign w_run    = ena & w_cnt_en & ~w_clr & ~w_load;
    assign w_pclear = ena & (w_clr | w_load);

    fjpolo_simple_counter_prescaler u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .clear (w_pclear),
        .sel   (w_psel),
        .tick  (w_tick)
    );

    assign w_at_max = (r_cnt == {WIDTH{1'b1}});
    assign w_at_min = (r_cnt == {WIDTH{1'b0}});

    // Step value: wrap naturally, or pin at the rail when saturating.
    always_comb begin
        w_next = r_cnt;
        if (w_dir) begin
            if (!(w_sat && w_at_min)) begin
                w_next = r_cnt - 1'b1;
            end
        end else begin
            if (!(w_sat && w_at_max)) begin
                w_next = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (ena) begin
            if (w_clr) begin
                r_cnt <= '0;
            end else if (w_load) begin
                r_cnt <= uio_in[WIDTH-1:0];
            end else if (w_tick) begin
                r_cnt <= w_next;
            end
        end
    end

    // WIDTH is expected to be 1..8; narrower counts are zero-extended.
    always_comb begin
        w_out = '0;
        w_out[WIDTH-1:0] = r_cnt;
    end

    assign uo_out  = w_out;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_fjpolo_simple_counter.sv
// Directed self-checking bench for fjpolo_simple_counter.
// Expected counts are queued at drive time and compared after each edge.
module tb_fjpolo_simple_counter;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int failures;
    logic [7:0] exp_q[$];

    fjpolo_simple_counter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, queue the expected count, check after the edge.
    task automatic cyc(input logic rn, input logic en,
                       input logic [7:0] ui, input logic [7:0] uv,
                       input logic [7:0] expv, input string tag);
        logic [7:0] e;
        rst_n  = rn;
        ena    = en;
        ui_in  = ui;
        uio_in = uv;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard_empty", tag);
        end else begin
            e = exp_q.pop_front();
            checks++;
            assert (uo_out === e) else begin
                failures++;
                $error("FAIL %s uo_out got=%h exp=%h", tag, uo_out, e);
            end
        end
        checks++;
        assert ((uio_out === 8'h00) && (uio_oe === 8'h00)) else begin
            failures++;
            $error("FAIL %s_uio got=%h/%h exp=00/00", tag, uio_out, uio_oe);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #2;

        // Reset, including with ena low and junk control
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, "reset");
        cyc(1'b0, 1'b1, 8'h15, 8'hAA, 8'h00, "reset_pri");

        // Up count every edge, N=0
        for (int i = 1; i <= 5; i++)
            cyc(1'b1, 1'b1, 8'h01, 8'h00, 8'(i), "up_n0");

        // Wrap up from FE
        cyc(1'b1, 1'b1, 8'h04, 8'hFE, 8'hFE, "load_fe");
        cyc(1'b1, 1'b1, 8'h01, 8'h00, 8'hFF, "wrap_up0");
        cyc(1'b1, 1'b1, 8'h01, 8'h00, 8'h00, "wrap_up1");
        cyc(1'b1, 1'b1, 8'h01, 8'h00, 8'h01, "wrap_up2");

        // Saturate up from FE
        cyc(1'b1, 1'b1, 8'h04, 8'hFE, 8'hFE, "load_fe2");
        cyc(1'b1, 1'b1, 8'h09, 8'h00, 8'hFF, "sat_up0");
        cyc(1'b1, 1'b1, 8'h09, 8'h00, 8'hFF, "sat_up1");
        cyc(1'b1, 1'b1, 8'h09, 8'h00, 8'hFF, "sat_up2");

        // Wrap down from 01
        cyc(1'b1, 1'b1, 8'h04, 8'h01, 8'h01, "load_01");
        cyc(1'b1, 1'b1, 8'h03, 8'h00, 8'h00, "wrap_dn0");
        cyc(1'b1, 1'b1, 8'h03, 8'h00, 8'hFF, "wrap_dn1");
        cyc(1'b1, 1'b1, 8'h03, 8'h00, 8'hFE, "wrap_dn2");

        // Saturate down from 01
        cyc(1'b1, 1'b1, 8'h04, 8'h01, 8'h01, "load_01b");
        cyc(1'b1, 1'b1, 8'h0B, 8'h00, 8'h00, "sat_dn0");
        cyc(1'b1, 1'b1, 8'h0B, 8'h00, 8'h00, "sat_dn1");
        cyc(1'b1, 1'b1, 8'h0B, 8'h00, 8'h00, "sat_dn2");

        // N=2: one step per 4 enabled cycles
        cyc(1'b1, 1'b1, 8'h10, 8'h00, 8'h00, "clr");
        for (int i = 1; i <= 8; i++)
            cyc(1'b1, 1'b1, 8'h41, 8'h00, 8'(i / 4), "n2_up");

        // cnt_en low holds pcnt without clearing it
        cyc(1'b1, 1'b1, 8'h41, 8'h00, 8'h02, "n2_pre0");
        cyc(1'b1, 1'b1, 8'h41, 8'h00, 8'h02, "n2_pre1");
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, 8'h40, 8'h00, 8'h02, "hold_en0");
        cyc(1'b1, 1'b1, 8'h41, 8'h00, 8'h02, "resume0");
        cyc(1'b1, 1'b1, 8'h41, 8'h00, 8'h03, "resume_tick");

        // pcnt=2 then switch to N=1: rolls through 127 before ticking
        cyc(1'b1, 1'b1, 8'h41, 8'h00, 8'h03, "pre_sw0");
        cyc(1'b1, 1'b1, 8'h41, 8'h00, 8'h03, "pre_sw1");
        for (int i = 0; i < 125; i++)
            cyc(1'b1, 1'b1, 8'h21, 8'h00, 8'h03, "sw_wait");
        cyc(1'b1, 1'b1, 8'h21, 8'h00, 8'h04, "sw_roll");
        cyc(1'b1, 1'b1, 8'h21, 8'h00, 8'h04, "n1_a");
        cyc(1'b1, 1'b1, 8'h21, 8'h00, 8'h05, "n1_b");

        // N=7: one step per 128 enabled cycles
        cyc(1'b1, 1'b1, 8'h10, 8'h00, 8'h00, "clr2");
        for (int i = 0; i < 127; i++)
            cyc(1'b1, 1'b1, 8'hE1, 8'h00, 8'h00, "n7_wait");
        cyc(1'b1, 1'b1, 8'hE1, 8'h00, 8'h01, "n7_tick");

        // Priority and enable gating
        cyc(1'b1, 1'b1, 8'h14, 8'hAA, 8'h00, "clr_over_load");
        cyc(1'b1, 1'b1, 8'h04, 8'h36, 8'h36, "load_36");
        cyc(1'b1, 1'b0, 8'h04, 8'hAA, 8'h36, "ena0_load");
        cyc(1'b1, 1'b0, 8'h11, 8'h00, 8'h36, "ena0_clr");
        cyc(1'b1, 1'b1, 8'h01, 8'h00, 8'h37, "step_37");
        cyc(1'b0, 1'b1, 8'h01, 8'h00, 8'h00, "rst_mid");
        cyc(1'b1, 1'b1, 8'h01, 8'h00, 8'h01, "post_rst");

        // Reset aborts a prescaler period
        cyc(1'b1, 1'b1, 8'h41, 8'h00, 8'h01, "abort0");
        cyc(1'b1, 1'b1, 8'h41, 8'h00, 8'h01, "abort1");
        cyc(1'b0, 1'b1, 8'h41, 8'h00, 8'h00, "abort_rst");
        for (int i = 1; i <= 4; i++)
            cyc(1'b1, 1'b1, 8'h41, 8'h00, 8'(i / 4), "fresh_n2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
